// File: rtl/cp0_regfile_if.sv
// Writeback-to-CP0 interface: exception/eret/mtc0 fields driven by writeback,
// plus the read data, eret target and interrupt flag returned by CP0.
interface cp0_regfile_if;
    logic        wb_ex;
    logic [4:0]  wb_excode;
    logic [31:0] wb_badvaddr;
    logic        wb_bd;
    logic [31:0] wb_pc;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        eret_flush;
    logic [31:0] cp0_rdata;
    logic [31:0] cp0_epc;
    logic [31:0] ex_entry;
    logic        int_pending;

    modport master (
        output wb_ex, wb_excode, wb_badvaddr, wb_bd, wb_pc,
               mtc0_we, cp0_addr, cp0_wdata, eret_flush,
        input  cp0_rdata, cp0_epc, ex_entry, int_pending
    );

    modport slave (
        input  wb_ex, wb_excode, wb_badvaddr, wb_bd, wb_pc,
               mtc0_we, cp0_addr, cp0_wdata, eret_flush,
        output cp0_rdata, cp0_epc, ex_entry, int_pending
    );
endinterface

// File: rtl/cp0_regfile.sv
// CP0 register file: Status, Cause, EPC, BadVAddr, Count and Compare.
// Takes exception/eret/mtc0 traffic from writeback, serves mfc0 reads,
// supplies the eret target and flags pending enabled interrupts to decode.
module cp0_regfile #(
    parameter logic [31:0] EX_ENTRY  = 32'hBFC00380,
    parameter int          COUNT_DIV = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [5:0]   hw_int,
    cp0_regfile_if.slave wb
);

    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic        cause_ti;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_excode;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic        div_phase;

    logic        take_ex;
    logic        take_eret;
    logic        mtc0_go;
    logic        count_tick;
    logic [31:0] status_word;
    logic [31:0] cause_word;

    // Decode writeback commands; an exception or eret in flight swallows any mtc0
    always_comb begin
        take_ex    = wb.wb_ex & ~wb.eret_flush;
        take_eret  = wb.wb_ex & wb.eret_flush;
        mtc0_go    = wb.mtc0_we & ~wb.wb_ex;
        count_tick = (COUNT_DIV == 1) ? 1'b1 : div_phase;
    end

    // Status: EXL follows exception/eret, otherwise IM/EXL/IE are mtc0-writable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_im  <= 8'd0;
            status_exl <= 1'b0;
            status_ie  <= 1'b0;
        end else if (take_ex) begin
            status_exl <= 1'b1;
        end else if (take_eret) begin
            status_exl <= 1'b0;
        end else if (mtc0_go && wb.cp0_addr == 5'd12) begin
            status_im  <= wb.cp0_wdata[15:8];
            status_exl <= wb.cp0_wdata[1];
            status_ie  <= wb.cp0_wdata[0];
        end
    end

    // Cause: hardware IP sampled each cycle, TI sticky until Compare is rewritten
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cause_bd     <= 1'b0;
            cause_ti     <= 1'b0;
            cause_ip_hw  <= 6'd0;
            cause_ip_sw  <= 2'd0;
            cause_excode <= 5'd0;
        end else begin
            cause_ip_hw <= {hw_int[5] | cause_ti, hw_int[4:0]};
            if (mtc0_go && wb.cp0_addr == 5'd11) begin
                cause_ti <= 1'b0;
            end else if (count == compare) begin
                cause_ti <= 1'b1;
            end
            if (take_ex) begin
                cause_excode <= wb.wb_excode;
                if (!status_exl) begin
                    cause_bd <= wb.wb_bd;
                end
            end else if (mtc0_go && wb.cp0_addr == 5'd13) begin
                cause_ip_sw <= wb.cp0_wdata[9:8];
            end
        end
    end

    // EPC: captured on the first exception of a nest, otherwise mtc0-writable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc <= 32'd0;
        end else if (take_ex) begin
            if (!status_exl) begin
                epc <= wb.wb_bd ? (wb.wb_pc - 32'd4) : wb.wb_pc;
            end
        end else if (mtc0_go && wb.cp0_addr == 5'd14) begin
            epc <= wb.cp0_wdata;
        end
    end

    // BadVAddr: only address-error exceptions load it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            badvaddr <= 32'd0;
        end else if (take_ex && (wb.wb_excode == 5'd4 || wb.wb_excode == 5'd5)) begin
            badvaddr <= wb.wb_badvaddr;
        end
    end

    // Count and its divider: an mtc0 to Count replaces the tick and freezes the phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= 32'd0;
            div_phase <= 1'b0;
        end else if (mtc0_go && wb.cp0_addr == 5'd9) begin
            count <= wb.cp0_wdata;
        end else begin
            if (count_tick) begin
                count <= count + 32'd1;
            end
            if (COUNT_DIV == 2) begin
                div_phase <= ~div_phase;
            end
        end
    end

    // Compare: plain mtc0-writable register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            compare <= 32'd0;
        end else if (mtc0_go && wb.cp0_addr == 5'd11) begin
            compare <= wb.cp0_wdata;
        end
    end

    // Assemble architectural Status/Cause views and the mfc0 read mux
    always_comb begin
        status_word  = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
        cause_word   = {cause_bd, cause_ti, 14'd0, cause_ip_hw, cause_ip_sw,
                        1'b0, cause_excode, 2'b00};
        wb.cp0_rdata = 32'd0;
        case (wb.cp0_addr)
            5'd8:    wb.cp0_rdata = badvaddr;
            5'd9:    wb.cp0_rdata = count;
            5'd11:   wb.cp0_rdata = compare;
            5'd12:   wb.cp0_rdata = status_word;
            5'd13:   wb.cp0_rdata = cause_word;
            5'd14:   wb.cp0_rdata = epc;
            default: wb.cp0_rdata = 32'd0;
        endcase
    end

    // Side outputs: eret target, vector and enabled-interrupt flag
    always_comb begin
        wb.cp0_epc     = epc;
        wb.ex_entry    = EX_ENTRY;
        wb.int_pending = (|({cause_ip_hw, cause_ip_sw} & status_im)) & status_ie & ~status_exl;
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Testbench for cp0_regfile: a word-level model of the CP0 registers is
// checked against the DUT on every falling edge, and directed sequences
// pin the model with hand-computed register values.
module tb_cp0_regfile;

    localparam logic [31:0] EX_ENTRY  = 32'hBFC00380;
    localparam int          COUNT_DIV = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] hw_int;
    int         checks = 0;
    int         errors = 0;

    cp0_regfile_if bus();

    cp0_regfile #(.EX_ENTRY(EX_ENTRY), .COUNT_DIV(COUNT_DIV)) dut (
        .clk    (clk),
        .reset  (reset),
        .hw_int (hw_int),
        .wb     (bus)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] bad;
        logic [31:0] count;
        logic [31:0] compare;
        int          phase;
    } model_t;

    model_t m;

    // Architectural next state computed on whole 32-bit register words
    function automatic model_t modelStep(input model_t cur, input logic [5:0] hw);
        model_t n;
        logic   wr;
        n  = cur;
        wr = bus.mtc0_we && !bus.wb_ex;
        n.cause[30] = (wr && bus.cp0_addr == 5'd11) ? 1'b0
                    : (cur.cause[30] | (cur.count == cur.compare));
        n.cause[15:10] = {hw[5] | cur.cause[30], hw[4:0]};
        if (bus.wb_ex && bus.eret_flush) begin
            n.status[1] = 1'b0;
        end else if (bus.wb_ex) begin
            if (!cur.status[1]) begin
                n.epc      = bus.wb_bd ? bus.wb_pc - 32'd4 : bus.wb_pc;
                n.cause[31] = bus.wb_bd;
            end
            n.status[1]  = 1'b1;
            n.cause[6:2] = bus.wb_excode;
            if (bus.wb_excode == 5'd4 || bus.wb_excode == 5'd5) n.bad = bus.wb_badvaddr;
        end else if (wr) begin
            case (bus.cp0_addr)
                5'd11: n.compare = bus.cp0_wdata;
                5'd12: n.status = (bus.cp0_wdata & 32'h0000FF03) | 32'h00400000;
                5'd13: n.cause[9:8] = bus.cp0_wdata[9:8];
                5'd14: n.epc = bus.cp0_wdata;
                default: ;
            endcase
        end
        if (wr && bus.cp0_addr == 5'd9) begin
            n.count = bus.cp0_wdata;
        end else begin
            if (cur.phase == COUNT_DIV - 1) n.count = cur.count + 32'd1;
            n.phase = (cur.phase + 1) % COUNT_DIV;
        end
        return n;
    endfunction

    function automatic logic [31:0] modelRead(input model_t cur, input logic [4:0] a);
        case (a)
            5'd8:    return cur.bad;
            5'd9:    return cur.count;
            5'd11:   return cur.compare;
            5'd12:   return cur.status;
            5'd13:   return cur.cause;
            5'd14:   return cur.epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic modelIntPending(input model_t cur);
        return ((cur.cause & cur.status & 32'h0000FF00) != 32'd0)
               && cur.status[0] && !cur.status[1];
    endfunction

    // Model state register with the same asynchronous reset as the DUT
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m <= '{32'h00400000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0};
        end else begin
            m <= modelStep(m, hw_int);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Compare every DUT output against the model mid-cycle
    always @(negedge clk) begin
        checkOutput("model_rdata", bus.cp0_rdata, modelRead(m, bus.cp0_addr));
        checkOutput("model_epc", bus.cp0_epc, m.epc);
        checkOutput("model_entry", bus.ex_entry, EX_ENTRY);
        checkOutput("model_int", {31'd0, bus.int_pending}, {31'd0, modelIntPending(m)});
    end

    // Drive one cycle of writeback traffic, launched just after a rising edge
    task automatic applyStimulus(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                                 input logic ex, input logic eret, input logic [4:0] excode,
                                 input logic bd, input logic [31:0] pc, input logic [31:0] badv);
        @(posedge clk);
        #1;
        bus.mtc0_we     = we;
        bus.cp0_addr    = addr;
        bus.cp0_wdata   = wdata;
        bus.wb_ex       = ex;
        bus.eret_flush  = eret;
        bus.wb_excode   = excode;
        bus.wb_bd       = bd;
        bus.wb_pc       = pc;
        bus.wb_badvaddr = badv;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, addr, data, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic readReg(input logic [4:0] addr, input logic [31:0] expected, input string name);
        applyStimulus(1'b0, addr, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        checkOutput(name, bus.cp0_rdata, expected);
    endtask

    initial begin
        logic found;
        hw_int          = 6'd0;
        bus.mtc0_we     = 1'b0;
        bus.cp0_addr    = 5'd12;
        bus.cp0_wdata   = 32'd0;
        bus.wb_ex       = 1'b0;
        bus.eret_flush  = 1'b0;
        bus.wb_excode   = 5'd0;
        bus.wb_bd       = 1'b0;
        bus.wb_pc       = 32'd0;
        bus.wb_badvaddr = 32'd0;
        reset           = 1'b0;
        #1 reset = 1'b1;
        #22 reset = 1'b0;

        $display("[TB] reset values");
        readReg(5'd12, 32'h00400000, "reset_status");
        checkOutput("reset_epc", bus.cp0_epc, 32'd0);
        checkOutput("ex_entry", bus.ex_entry, 32'hBFC00380);

        $display("[TB] writable masks");
        mtc0(5'd12, 32'hFFFFFFFF);
        readReg(5'd12, 32'h0040FF03, "status_mask");
        mtc0(5'd11, 32'hFFFFFFF0);
        mtc0(5'd13, 32'hFFFFFFFF);
        readReg(5'd13, 32'h00000300, "cause_mask");
        mtc0(5'd10, 32'hFFFFFFFF);
        readReg(5'd10, 32'h00000000, "unmapped_read");
        mtc0(5'd13, 32'd0);
        mtc0(5'd12, 32'd0);

        $display("[TB] exceptions");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd4, 1'b1, 32'hBFC00104, 32'h00000001);
        readReg(5'd14, 32'hBFC00100, "ex1_epc");
        readReg(5'd13, 32'h80000010, "ex1_cause");
        readReg(5'd8, 32'h00000001, "ex1_badvaddr");
        readReg(5'd12, 32'h00400002, "ex1_status");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd8, 1'b0, 32'h80000000, 32'h0000DEAD);
        readReg(5'd14, 32'hBFC00100, "ex2_epc");
        readReg(5'd13, 32'h80000020, "ex2_cause");
        readReg(5'd8, 32'h00000001, "ex2_badvaddr");

        $display("[TB] eret and suppressed mtc0");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd0, 1'b0, 32'h80000010, 32'd0);
        readReg(5'd12, 32'h00400000, "eret_status");
        checkOutput("eret_epc", bus.cp0_epc, 32'hBFC00100);
        applyStimulus(1'b1, 5'd14, 32'h12345678, 1'b1, 1'b0, 5'd0, 1'b0, 32'h80001000, 32'd0);
        readReg(5'd14, 32'h80001000, "ex_drops_mtc0");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd0, 1'b0, 32'd0, 32'd0);

        $display("[TB] timer interrupt");
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        mtc0(5'd12, 32'h00008001);
        applyStimulus(1'b0, 5'd13, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.cp0_rdata[30]) found = 1'b1;
        end
        checkOutput("ti_seen", {31'd0, found}, 32'd1);
        #1 bus.cp0_addr = 5'd9;
        #1 checkOutput("count_at_ti", bus.cp0_rdata, 32'd5);
        @(negedge clk);
        checkOutput("timer_int", {31'd0, bus.int_pending}, 32'd1);
        mtc0(5'd11, 32'h00000100);
        readReg(5'd13, 32'h00008000, "ti_cleared");
        readReg(5'd13, 32'h00000000, "ip7_cleared");
        checkOutput("timer_int_off", {31'd0, bus.int_pending}, 32'd0);

        $display("[TB] hardware interrupt");
        hw_int = 6'b000001;
        mtc0(5'd12, 32'h00000401);
        readReg(5'd13, 32'h00000400, "hw_ip");
        checkOutput("hw_int", {31'd0, bus.int_pending}, 32'd1);
        hw_int = 6'd0;

        $display("[TB] reset mid-operation");
        mtc0(5'd12, 32'h0000FF03);
        readReg(5'd12, 32'h0040FF03, "pre_reset_status");
        #2 reset = 1'b1;
        #1 checkOutput("async_reset_status", bus.cp0_rdata, 32'h00400000);
        bus.cp0_addr = 5'd9;
        #1 checkOutput("async_reset_count", bus.cp0_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- CP0 register file. It is the receiving end of the writeback-to-CP0 interface.
- It consumes the exception, eret and mtc0 fields that writeback drives.
- It holds Status, Cause, EPC, BadVAddr, Count and Compare.
- It returns mfc0 read data and the eret target PC, and raises a pending-interrupt flag toward decode.

Parameters:
- EX_ENTRY, 32'hBFC00380, exception handler PC driven on ex_entry.
- COUNT_DIV, 2, Count increments once every COUNT_DIV cycles (legal values 1 or 2).

Ports:
- clk  input  1  clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high reset
- wb_ex  input  1  exception or eret flush from writeback (already gated by ws_valid)
- wb_excode  input  5  ExcCode of the faulting instruction
- wb_badvaddr  input  32  faulting virtual address
- wb_bd  input  1  faulting instruction sits in a delay slot
- wb_pc  input  32  PC of the writeback instruction
- mtc0_we  input  1  mtc0 write enable
- cp0_addr  input  5  CP0 register number, used for both read and write; sel is always 0
- cp0_wdata  input  32  mtc0 data (rt value)
- eret_flush  input  1  eret retiring; asserted together with wb_ex
- hw_int  input  6  external interrupt lines, level-sensitive
- cp0_rdata  output  32  mfc0 read data
- cp0_epc  output  32  current EPC, used as the eret target
- ex_entry  output  32  exception vector, constant EX_ENTRY
- int_pending  output  1  an enabled interrupt is pending

Behaviour:
Reset values (asynchronous):
- Status = 32'h00400000 (BEV=1, all else 0).
- Cause, EPC, BadVAddr, Count, Compare = 0.
- Count divider phase = 0.

Register map and fields:
- 8 BadVAddr: read-only to mtc0.
- 9 Count: read/write.
- 11 Compare: read/write. An mtc0 to Compare also clears Cause.TI.
- 12 Status: writable bits IM[15:8], EXL[1], IE[0]. BEV[22] reads as 1. All other bits read 0.
- 13 Cause: only IP[9:8] writable. BD[31], TI[30], IP[15:10] and ExcCode[6:2] are read-only to mtc0.
- 14 EPC: read/write.
- Any other address reads 0; mtc0 to it is ignored.

Read path:
- cp0_rdata is a combinational mux of the current register state on cp0_addr.
- No bypass: an mtc0 in cycle N is visible from cycle N+1.

Cause hardware fields:
- IP[15:10] is sampled every cycle: IP[15] = hw_int[5] | TI; IP[14:10] = hw_int[4:0].

Count/Compare:
- Count increments when the divider phase wraps: with COUNT_DIV=2, every second cycle; with COUNT_DIV=1, every cycle. It wraps 32'hFFFFFFFF -> 0.
- An mtc0 to Count overrides the increment in that cycle and leaves the divider phase unchanged.
- TI is set on any cycle where Count == Compare and stays set until an mtc0 to Compare.
- If an mtc0 to Compare occurs in the same cycle as a match, the clear wins.

Exception (wb_ex=1, eret_flush=0):
- If EXL=0: EPC <= wb_bd ? wb_pc-4 : wb_pc, and Cause.BD <= wb_bd.
- If EXL=1: EPC and BD are unchanged.
- Always: EXL <= 1 and ExcCode <= wb_excode.
- BadVAddr <= wb_badvaddr only when wb_excode is 4 (AdEL) or 5 (AdES).

Eret (wb_ex=1, eret_flush=1):
- EXL <= 0. No other register changes.

Priority and suppression:
- When wb_ex=1, mtc0_we is ignored in that cycle.
- The TI set/clear logic and Count increment still run in that cycle.

Interrupt flag:
- int_pending = |(Cause[15:8] & Status[15:8]) & IE & ~EXL, computed combinationally from registered state.

Outputs:
- cp0_epc = EPC register.
- ex_entry = EX_ENTRY constant.
- Latency: every state update takes effect at the next rising edge.

Test Plan:
- Reset mid-operation: drive mtc0 writes, then assert reset asynchronously between edges -> Status reads 32'h00400000 immediately; Count reads 0.
- mtc0 Status 32'hFFFFFFFF, then mfc0 addr 12 -> 32'h0040FF03; mfc0 addr 13 after mtc0 Cause 32'hFFFFFFFF -> only bits 9:8 set.
- Exception with wb_excode=4, wb_bd=1, wb_pc=32'hBFC00104, wb_badvaddr=32'h1 -> EPC=32'hBFC00100, BD=1, ExcCode=4, BadVAddr=1, EXL=1.
- Second exception while EXL=1, with wb_pc=32'h80000000 and excode=8 -> EPC unchanged, ExcCode=8, BadVAddr unchanged.
- Eret: EXL cleared and cp0_epc unchanged. Exception with mtc0_we=1 to EPC in the same cycle -> the mtc0 is dropped.
- Timer interrupt: mtc0 Compare=5, Count=0, Status=32'h00008001 -> Count reaches 5 after 10 cycles; TI=1, int_pending=1. Then mtc0 Compare -> TI=0, int_pending=0.
